// File: rtl/demux1to4_reg32_if.sv
// Producer-side bus of the 1-to-4 holding-register demux: write/release controls in,
// four slot registers and their status out.
interface demux1to4_reg32_if #(
    parameter int WIDTH = 32
);
    logic             WrEn;
    logic             AutoInc;
    logic [1:0]       sel;
    logic [WIDTH-1:0] DataIn;
    logic [3:0]       Clr;
    logic [WIDTH-1:0] DataOut1;
    logic [WIDTH-1:0] DataOut2;
    logic [WIDTH-1:0] DataOut3;
    logic [WIDTH-1:0] DataOut4;
    logic [3:0]       Valid;
    logic [1:0]       WrPtr;
    logic             Full;
    logic             Overrun;

    modport master (
        output WrEn, AutoInc, sel, DataIn, Clr,
        input  DataOut1, DataOut2, DataOut3, DataOut4, Valid, WrPtr, Full, Overrun
    );

    modport slave (
        input  WrEn, AutoInc, sel, DataIn, Clr,
        output DataOut1, DataOut2, DataOut3, DataOut4, Valid, WrPtr, Full, Overrun
    );
endinterface

// File: rtl/demux1to4_reg32.sv
// Steers one shared result bus into one of four holding registers, chosen by an explicit
// select or a round-robin pointer, with per-slot occupancy, release and a sticky overrun flag.
module demux1to4_reg32 #(
    parameter int WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    demux1to4_reg32_if.slave      bus
);
    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [1:0]       r_wr_ptr;
    logic             r_overrun;

    logic [1:0]       w_target;
    logic [3:0]       w_wr_onehot;
    logic             w_overwrite;

    // Destination slot and its one-hot write enable, from pre-edge values.
    always_comb begin
        w_target    = 2'd0;
        w_wr_onehot = 4'b0000;
        if (bus.AutoInc) begin
            w_target = r_wr_ptr;
        end else begin
            w_target = bus.sel;
        end
        if (bus.WrEn) begin
            case (w_target)
                2'd0:    w_wr_onehot = 4'b0001;
                2'd1:    w_wr_onehot = 4'b0010;
                2'd2:    w_wr_onehot = 4'b0100;
                2'd3:    w_wr_onehot = 4'b1000;
                default: w_wr_onehot = 4'b0000;
            endcase
        end else begin
            w_wr_onehot = 4'b0000;
        end
    end

    // A slot released on the same edge it is rewritten is not an overrun.
    assign w_overwrite = bus.WrEn & r_valid[w_target] & ~bus.Clr[w_target];

    // Slot data, occupancy, pointer and overrun state.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            for (int i = 0; i < 4; i++) begin
                r_data[i] <= {WIDTH{1'b0}};
            end
            r_valid   <= 4'b0000;
            r_wr_ptr  <= 2'd0;
            r_overrun <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr_onehot[i]) begin
                    r_data[i] <= bus.DataIn;
                end else begin
                    r_data[i] <= r_data[i];
                end
            end
            // Write wins over release on the same slot.
            r_valid <= (r_valid & ~bus.Clr) | w_wr_onehot;
            if (bus.WrEn && bus.AutoInc) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_overwrite) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign bus.DataOut1 = r_data[0];
    assign bus.DataOut2 = r_data[1];
    assign bus.DataOut3 = r_data[2];
    assign bus.DataOut4 = r_data[3];
    assign bus.Valid    = r_valid;
    assign bus.WrPtr    = r_wr_ptr;
    assign bus.Full     = &r_valid;
    assign bus.Overrun  = r_overrun;
endmodule

// File: tb/tb_demux1to4_reg32.sv
// Scoreboarded bench for demux1to4_reg32: a behavioural model queues the expected outputs
// for every driven edge, and each scenario task pops and compares them after the edge.
module tb_demux1to4_reg32;
    logic CLK;
    logic Reset;

    demux1to4_reg32_if #(.WIDTH(32)) bus ();

    demux1to4_reg32 #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        logic [3:0]  v;
        logic [1:0]  p;
        logic        f;
        logic        o;
    } snap_t;

    snap_t       sb [$];
    snap_t       got;
    snap_t       exp;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_data [4];
    logic [3:0]  m_valid;
    logic [1:0]  m_ptr;
    logic        m_ovr;

    function automatic snap_t observe();
        snap_t s;
        s.d0 = bus.DataOut1;
        s.d1 = bus.DataOut2;
        s.d2 = bus.DataOut3;
        s.d3 = bus.DataOut4;
        s.v  = bus.Valid;
        s.p  = bus.WrPtr;
        s.f  = bus.Full;
        s.o  = bus.Overrun;
        return s;
    endfunction

    // Drive one edge, push the model's expected outputs, then wait until just after the edge.
    task automatic cycle(input logic rst, input logic we, input logic ai,
                         input logic [1:0] s, input logic [31:0] d, input logic [3:0] c);
        logic [1:0] t;
        logic [3:0] nv;
        snap_t      e;
        Reset       = rst;
        bus.WrEn    = we;
        bus.AutoInc = ai;
        bus.sel     = s;
        bus.DataIn  = d;
        bus.Clr     = c;
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_data[i] = 32'h0;
            m_valid = 4'b0000;
            m_ptr   = 2'd0;
            m_ovr   = 1'b0;
        end else begin
            t  = ai ? m_ptr : s;
            nv = m_valid & ~c;
            if (we && m_valid[t] && !c[t]) m_ovr = 1'b1;
            if (we) begin
                m_data[t] = d;
                nv[t]     = 1'b1;
                if (ai) m_ptr = m_ptr + 2'd1;
            end
            m_valid = nv;
        end
        e.d0 = m_data[0]; e.d1 = m_data[1]; e.d2 = m_data[2]; e.d3 = m_data[3];
        e.v  = m_valid;   e.p  = m_ptr;     e.f  = &m_valid;  e.o  = m_ovr;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        exp = sb.pop_front(); got = observe(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_init got=%h exp=%h", got, exp); end
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 4'h0);
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL reset_prefill got=%h exp=%h", got, exp); end
        end
        cycle(1'b0, 1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 4'h0);
        exp = sb.pop_front(); got = observe(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL reset_sb got=%h exp=%h", got, exp); end
        n_checks++;
        if (got !== 136'h0) begin n_fail++; $display("FAIL reset_zero got=%h exp=0", got); end
    endtask

    task automatic test_explicit();
        cycle(1'b1, 1'b1, 1'b0, 2'b10, 32'hAAAA0001, 4'h0);
        exp = sb.pop_front(); got = observe(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL explicit_sb got=%h exp=%h", got, exp); end
        n_checks++;
        if (got.d2 !== 32'hAAAA0001 || got.v !== 4'b0100 || got.p !== 2'd0 || got.d0 !== 32'h0 ||
            got.d1 !== 32'h0 || got.d3 !== 32'h0 || got.f !== 1'b0 || got.o !== 1'b0) begin
            n_fail++; $display("FAIL explicit_sel2 got=%h exp d2=aaaa0001 v=0100 others 0", got);
        end
    endtask

    task automatic test_autoinc();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        void'(sb.pop_front());
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 2'd3, 32'h10 + 32'(k), 4'h0);
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL autoinc_sb[%0d] got=%h exp=%h", k, got, exp); end
            if (k == 3) begin
                n_checks++;
                if (got.f !== 1'b1 || got.p !== 2'd0 || got.o !== 1'b0) begin
                    n_fail++; $display("FAIL autoinc_full got f=%b p=%0d o=%b exp f=1 p=0 o=0", got.f, got.p, got.o);
                end
            end
        end
        n_checks++;
        if (got.d0 !== 32'h14 || got.d1 !== 32'h11 || got.d2 !== 32'h12 || got.d3 !== 32'h13 ||
            got.p !== 2'd1 || got.o !== 1'b1) begin
            n_fail++; $display("FAIL autoinc_wrap got=%h exp d=14,11,12,13 p=1 o=1", got);
        end
    endtask

    task automatic test_write_clr_same();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        void'(sb.pop_front());
        cycle(1'b1, 1'b1, 1'b0, 2'b01, 32'h7, 4'h0);
        exp = sb.pop_front(); got = observe(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL wrclr_fill got=%h exp=%h", got, exp); end
        cycle(1'b1, 1'b1, 1'b0, 2'b01, 32'h5, 4'b0010);
        exp = sb.pop_front(); got = observe(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL wrclr_sb got=%h exp=%h", got, exp); end
        n_checks++;
        if (got.v[1] !== 1'b1 || got.d1 !== 32'h5 || got.o !== 1'b0) begin
            n_fail++; $display("FAIL wrclr_same got v1=%b d1=%h o=%b exp v1=1 d1=5 o=0", got.v[1], got.d1, got.o);
        end
    endtask

    task automatic test_clear_all();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        void'(sb.pop_front());
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 2'd0, 32'h20 + 32'(k), 4'h0);
            void'(sb.pop_front());
        end
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        exp = sb.pop_front(); got = observe(); n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL clrall_sb got=%h exp=%h", got, exp); end
        n_checks++;
        if (got.v !== 4'b0000 || got.f !== 1'b0 || got.d0 !== 32'h20 || got.d1 !== 32'h21 ||
            got.d2 !== 32'h22 || got.d3 !== 32'h23) begin
            n_fail++; $display("FAIL clrall_keep got=%h exp v=0 f=0 d=20,21,22,23", got);
        end
    endtask

    task automatic test_reset_during_write();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        void'(sb.pop_front());
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 2'd0, 32'h30 + 32'(k), 4'h0);
            void'(sb.pop_front());
        end
        got = observe(); n_checks++;
        if (got.p !== 2'd2 || got.o !== 1'b1) begin
            n_fail++; $display("FAIL rstwr_pre got p=%0d o=%b exp p=2 o=1", got.p, got.o);
        end
        cycle(1'b0, 1'b1, 1'b1, 2'd0, 32'hDEAD_BEEF, 4'h0);
        exp = sb.pop_front(); got = observe(); n_checks++;
        if (got !== 136'h0 || got !== exp) begin n_fail++; $display("FAIL rstwr_reset got=%h exp=0", got); end
        cycle(1'b1, 1'b1, 1'b1, 2'd2, 32'hBEEF_0001, 4'h0);
        exp = sb.pop_front(); got = observe(); n_checks++;
        if (got.d0 !== 32'hBEEF_0001 || got.v !== 4'b0001 || got.p !== 2'd1 || got !== exp) begin
            n_fail++; $display("FAIL rstwr_next got=%h exp d0=beef0001 v=0001 p=1", got);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 60; k++) begin
            cycle(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
            exp = sb.pop_front(); got = observe(); n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL b2b[%0d] got=%h exp=%h", k, got, exp); end
        end
    endtask

    initial begin
        Reset = 1'b0; bus.WrEn = 1'b0; bus.AutoInc = 1'b0;
        bus.sel = 2'd0; bus.DataIn = 32'h0; bus.Clr = 4'h0;
        test_reset();
        test_explicit();
        test_autoinc();
        test_write_clr_same();
        test_clear_all();
        test_reset_during_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
